// File: rtl/zeroheti_dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin core.
// The window helper decodes in 33 bits so the top of the address space cannot wrap into range.
package zeroheti_dmem_arb_pkg;

  localparam int unsigned DmemArbMaxReq = 4;
  localparam int unsigned DmemWSize     = 4096;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] size;
  } addr_rule_t;

  localparam addr_rule_t DmemAddr = '{base: 32'h0002_0000, size: 32'h0000_4000};

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] a33;
    logic [32:0] b33;
    a33 = {1'b0, addr};
    b33 = {1'b0, base};
    return (a33 >= b33) && (a33 < (b33 + span));
  endfunction

endpackage

// File: rtl/zeroheti_dmem_arb_rr.sv
// Combinational round-robin pick: first asserted request at or after prio_i, wrapping upward.
// Kept standalone so the HETIC bus port can reuse it.
module zeroheti_rr_arb #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned PW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PW-1:0]     prio_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PW-1:0]     idx_o,
  output logic              valid_o
);

  logic [PW-1:0] cand_s;

  // Scan ports starting at the priority pointer; the first live request wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_s = PW'((32'(prio_i) + i) % NumReq);
      if (!valid_o && req_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
        valid_o       = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/zeroheti_dmem_arb.sv
// Shares the single-port data SRAM between NumReq OBI-style requesters with round-robin
// arbitration, a window check, and a one-cycle response stage routed back to the winner.
module zeroheti_dmem_arb
  import zeroheti_dmem_arb_pkg::*;
#(
  parameter  int unsigned NumReq   = 2,
  parameter  int unsigned MemWords = DmemWSize,
  parameter  logic [31:0] BaseAddr = DmemAddr.base,
  localparam int unsigned AW       = $clog2(MemWords),
  localparam int unsigned PW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_i,
  input  logic [NumReq-1:0]      we_i,
  input  logic [NumReq-1:0][3:0] be_i,
  input  logic [NumReq-1:0][31:0] addr_i,
  input  logic [NumReq-1:0][31:0] wdata_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic [NumReq-1:0]      rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_be_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i
);

  localparam logic [32:0] SpanBytes = 33'(MemWords) << 2;

  logic [NumReq-1:0] req_s;
  logic [PW-1:0]     win_idx_s;
  logic              any_gnt_s;
  logic              in_range_s;
  logic [31:0]       offset_s;
  logic [PW-1:0]     prio_d_s;

  logic [PW-1:0]     prio_q;
  logic              rsp_valid_q;
  logic [PW-1:0]     rsp_port_q;
  logic              rsp_err_q;
  logic              rsp_we_q;

  // Reset suppresses all grants even while requests are held.
  assign req_s = rst_i ? '0 : req_i;

  zeroheti_rr_arb #(.NumReq(NumReq)) u_rr (
    .req_i   (req_s),
    .prio_i  (prio_q),
    .gnt_o   (gnt_o),
    .idx_o   (win_idx_s),
    .valid_o (any_gnt_s)
  );

  assign in_range_s = in_window(addr_i[win_idx_s], BaseAddr, SpanBytes);
  assign offset_s   = addr_i[win_idx_s] - BaseAddr;

  // SRAM strobe only for in-range winners; out-of-range grants still complete with an error.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0000_0000;
    if (any_gnt_s && in_range_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[win_idx_s];
      mem_be_o    = be_i[win_idx_s];
      mem_addr_o  = AW'(offset_s >> 2);
      mem_wdata_o = wdata_i[win_idx_s];
    end else begin
    end
  end

  // Pointer moves one past the winner; wraps to port 0 after the last port.
  always_comb begin
    prio_d_s = prio_q;
    if (any_gnt_s) begin
      prio_d_s = (32'(win_idx_s) == NumReq - 1) ? '0 : win_idx_s + 1'b1;
    end else begin
    end
  end

  // Priority pointer and single-entry response stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else if (any_gnt_s) begin
      prio_q      <= prio_d_s;
      rsp_valid_q <= 1'b1;
      rsp_port_q  <= win_idx_s;
      rsp_err_q   <= !in_range_s;
      rsp_we_q    <= we_i[win_idx_s];
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Gating on rst_i drops a response that was in flight when reset arrived.
  always_comb begin
    rvalid_o = '0;
    err_o    = 1'b0;
    rdata_o  = 32'h0000_0000;
    if (rsp_valid_q && !rst_i) begin
      rvalid_o[rsp_port_q] = 1'b1;
      err_o                = rsp_err_q;
      rdata_o              = (rsp_err_q || rsp_we_q) ? 32'h0000_0000 : mem_rdata_i;
    end else begin
    end
  end

endmodule

// File: tb/tb_zeroheti_dmem_arb.sv
// Scoreboard bench for zeroheti_dmem_arb (NumReq=2, 4096 words at 0x0002_0000).
// A reference arbiter and memory image predict grants and responses; a separate SRAM model feeds the DUT.
module tb_zeroheti_dmem_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [3:0]       mem_be_o;
  logic [11:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  typedef struct {
    logic [1:0]  port_oh;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] sram[4096];
  logic [31:0] exp_mem[4096];
  int          exp_prio = 0;

  zeroheti_dmem_arb #(.NumReq(2), .MemWords(4096), .BaseAddr(32'h0002_0000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // SRAM model driven only by the DUT's memory port.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
      mem_rdata <= sram[mem_addr_o];
    end
  end

  // Scoreboard: check the response due now, then predict this cycle's grant.
  always @(negedge clk) begin
    if (run) begin
      exp_t        e;
      logic [1:0]  exp_g;
      int          w;
      longint      a;
      logic        in_r;
      logic [31:0] nw;
      if (rst) begin
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        sb_q.delete();
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rvalid", 32'(rvalid_o), 32'(e.port_oh));
        chk("err", 32'(err_o), 32'(e.err));
        chk("rdata", rdata_o, e.rdata);
      end else begin
        chk("idle_rvalid", 32'(rvalid_o), 32'h0);
      end

      exp_g = 2'b00;
      w     = -1;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          int k;
          k = (exp_prio + i) % 2;
          if (w < 0 && req[k]) w = k;
        end
      end
      if (w >= 0) exp_g[w] = 1'b1;
      chk("gnt", 32'(gnt_o), 32'(exp_g));

      if (rst) begin
        exp_prio = 0;
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
      end else if (w >= 0) begin
        exp_prio = (w + 1) % 2;
        a        = longint'(addr[w]);
        in_r     = (a >= 64'h2_0000) && (a < 64'h2_4000);
        chk("mem_req", 32'(mem_req_o), 32'(in_r));
        e.port_oh = exp_g;
        e.err     = !in_r;
        e.rdata   = 32'h0;
        if (in_r) begin
          int wi;
          wi = int'((a - 64'h2_0000) >> 2);
          chk("mem_addr", 32'(mem_addr_o), 32'(wi));
          chk("mem_we", 32'(mem_we_o), 32'(we[w]));
          if (we[w]) begin
            chk("mem_be", 32'(mem_be_o), 32'(be[w]));
            nw = exp_mem[wi];
            for (int b = 0; b < 4; b++) begin
              if (be[w][b]) nw[8*b +: 8] = wdata[w][8*b +: 8];
            end
            exp_mem[wi] = nw;
          end else begin
            e.rdata = exp_mem[wi];
          end
        end
        sb_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic w, input logic [3:0] b,
                       input logic [31:0] ad, input logic [31:0] d);
    req[p]   = 1'b1;
    we[p]    = w;
    be[p]    = b;
    addr[p]  = ad;
    wdata[p] = d;
  endtask

  task automatic idle();
    req   = 2'b00;
    we    = 2'b00;
    be    = '0;
    addr  = '0;
    wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
      exp_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
    end
    sram[4]    = 32'hDEAD_BEEF;
    exp_mem[4] = 32'hDEAD_BEEF;
    sram[2]    = 32'hAABB_CCDD;
    exp_mem[2] = 32'hAABB_CCDD;
    mem_rdata  = 32'h0;
    rst = 1'b1;
    idle();
    run = 1'b1;
    step();
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    step();
    rst = 1'b0;

    // single read from port 0
    drive(0, 1'b0, 4'hF, 32'h0002_0010, 32'h0);
    step();
    idle();
    step();

    // contention straight after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 4'hF, 32'h0002_0000, 32'h0);
    drive(1, 1'b0, 4'hF, 32'h0002_0004, 32'h0);
    repeat (6) step();
    idle();
    step();

    // window edges
    drive(1, 1'b0, 4'hF, 32'h0002_4000, 32'h0);
    step();
    drive(1, 1'b0, 4'hF, 32'h0002_3FFC, 32'h0);
    step();
    idle();
    step();

    // byte write and read back
    drive(0, 1'b1, 4'b0100, 32'h0002_0008, 32'h1122_3344);
    step();
    drive(0, 1'b0, 4'hF, 32'h0002_0008, 32'h0);
    step();
    idle();
    step();

    // reset right after a port-1 grant
    drive(1, 1'b0, 4'hF, 32'h0002_0004, 32'h0);
    step();
    rst = 1'b1;
    drive(0, 1'b0, 4'hF, 32'h0002_0000, 32'h0);
    step();
    rst = 1'b0;
    step();
    idle();
    step();

    // underflow and overflow addresses
    drive(0, 1'b0, 4'hF, 32'h0001_FFFC, 32'h0);
    step();
    drive(0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
    step();
    idle();
    step();
    step();
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
